// File: rtl/mips_instr_loader.sv
// mips_instr_loader: encodes field-level MIPS instruction records into 32-bit words, buffers
// them in a small FIFO and writes them sequentially into instruction memory from a base address.
// Optional feature macro: MIPS_LOADER_CHECKSUM_EN adds an XOR checksum of every word written in
// the current session; without it checksum_o is tied to zero.
module mips_instr_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              finish_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        in_kind_i,
  input  logic [4:0]        in_rs_i,
  input  logic [4:0]        in_rt_i,
  input  logic [4:0]        in_rd_i,
  input  logic [5:0]        in_funct_i,
  input  logic [15:0]       in_imm_i,
  input  logic [25:0]       in_target_i,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       checksum_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              err_q;
  logic              done_q;

  logic        enc_legal;
  logic [31:0] enc_word;
  logic        session_start;
  logic        fifo_empty, fifo_full;
  logic        accept, push;

  // Field-level record to 32-bit MIPS word; kinds 6-7 are flagged illegal.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (in_kind_i)
      3'd0:    enc_word = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'b00000, in_funct_i};
      3'd1:    enc_word = {6'b100011, in_rs_i, in_rt_i, in_imm_i};
      3'd2:    enc_word = {6'b101011, in_rs_i, in_rt_i, in_imm_i};
      3'd3:    enc_word = {6'b000100, in_rs_i, in_rt_i, in_imm_i};
      3'd4:    enc_word = {6'b001000, in_rs_i, in_rt_i, in_imm_i};
      3'd5:    enc_word = {6'b000010, in_target_i};
      default: enc_legal = 1'b0;
    endcase
  end

  assign session_start = (state_q == StIdle) & start_i;
  assign fifo_empty    = (cnt_q == '0);
  assign fifo_full     = (cnt_q == FullCnt);
  assign busy_o        = (state_q == StLoad) | (state_q == StDrain);
  // A full FIFO refuses records even when a pop happens in the same cycle.
  assign in_ready_o    = (state_q == StLoad) & ~fifo_full;
  assign accept        = in_valid_i & in_ready_o;
  assign push          = accept & enc_legal;
  assign mem_we_o      = busy_o & ~fifo_empty & mem_ready_i;
  assign mem_addr_o    = addr_q;
  // Masked while empty so stale storage never shows on the bus.
  assign mem_wdata_o   = fifo_empty ? 32'h0 : fifo_q[rd_ptr_q];
  assign err_o         = err_q;
  assign done_o        = done_q;

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Session next-state: start only in idle, finish only in load, drain until FIFO empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StLoad;
      StLoad:  if (finish_i) state_d = StDrain;
      StDrain: if (fifo_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Write-address counter, FIFO pointers/occupancy, sticky error and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == StDrain) & fifo_empty;
      if (session_start) begin
        addr_q   <= base_addr_i;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        err_q    <= 1'b0;
      end else begin
        // Counter wraps silently at the top of the address space.
        if (mem_we_o) begin
          addr_q   <= addr_q + ADDR_W'(1);
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
        if (push & ~mem_we_o) begin
          cnt_q <= cnt_q + CntW'(1);
        end else if (~push & mem_we_o) begin
          cnt_q <= cnt_q - CntW'(1);
        end
        if (accept & ~enc_legal) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents are only observable through a non-empty head.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= enc_word;
    end
  end

`ifdef MIPS_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  // XOR of every word written this session; held after done until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (session_start) begin
      checksum_q <= '0;
    end else if (mem_we_o) begin
      checksum_q <= checksum_q ^ mem_wdata_o;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_mips_instr_loader.sv
// Self-checking bench for mips_instr_loader: table of hand-encoded vectors, directed corner
// sequences, and randomized sessions checked against a queue-based reference model.
module tb_mips_instr_loader;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } rec_t;

  typedef struct {
    rec_t        r;
    logic [31:0] word;
  } vec_t;

`ifdef MIPS_LOADER_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, finish_i, in_valid_i, in_ready_o, mem_ready_i;
  logic [7:0]  base_addr_i;
  logic [2:0]  in_kind_i;
  logic [4:0]  in_rs_i, in_rt_i, in_rd_i;
  logic [5:0]  in_funct_i;
  logic [15:0] in_imm_i;
  logic [25:0] in_target_i;
  logic        mem_we_o, busy_o, done_o, err_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o, checksum_o;

  int n_cmp  = 0;
  int n_fail = 0;
  bit rnd_ready = 1'b0;
  logic [39:0] got[$];

  mips_instr_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .finish_i(finish_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_kind_i(in_kind_i), .in_rs_i(in_rs_i), .in_rt_i(in_rt_i), .in_rd_i(in_rd_i),
    .in_funct_i(in_funct_i), .in_imm_i(in_imm_i), .in_target_i(in_target_i),
    .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  // Record every memory write; inputs are stable between negedge and the next posedge.
  always @(negedge clk) begin
    if (mem_we_o) got.push_back({mem_addr_o, mem_wdata_o});
  end

  // Random memory back-pressure for the randomized phase.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      mem_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder straight from the instruction-format table.
  function automatic bit model_encode(input rec_t r, output logic [31:0] w);
    logic [5:0] op;
    w = 32'h0;
    case (r.kind)
      3'd0: begin w = {6'd0, r.rs, r.rt, r.rd, 5'd0, r.funct}; return 1'b1; end
      3'd5: begin w = {6'b000010, r.target}; return 1'b1; end
      3'd1: op = 6'b100011;
      3'd2: op = 6'b101011;
      3'd3: op = 6'b000100;
      3'd4: op = 6'b001000;
      default: return 1'b0;
    endcase
    w = {op, r.rs, r.rt, r.imm};
    return 1'b1;
  endfunction

  task automatic drive_rec(input rec_t r);
    in_kind_i = r.kind; in_rs_i = r.rs; in_rt_i = r.rt; in_rd_i = r.rd;
    in_funct_i = r.funct; in_imm_i = r.imm; in_target_i = r.target;
  endtask

  task automatic start_session(input logic [7:0] base);
    start_i = 1'b1; base_addr_i = base;
    tick();
    start_i = 1'b0;
  endtask

  task automatic finish_session();
    finish_i = 1'b1;
    tick();
    finish_i = 1'b0;
  endtask

  task automatic push_rec(input rec_t r);
    int n = 0;
    drive_rec(r);
    in_valid_i = 1'b1;
    while (!in_ready_o && n < 200) begin tick(); n++; end
    if (n >= 200) check("push_ready_timeout", {31'b0, in_ready_o}, 32'd1);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_o && n < 500) begin tick(); n++; end
    check(name, {31'b0, done_o}, 32'd1);
  endtask

  function automatic rec_t mk(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                              input logic [25:0] tgt);
    rec_t r;
    r.kind = k; r.rs = rs; r.rt = rt; r.rd = rd; r.funct = f; r.imm = imm; r.target = tgt;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.kind = 3'($urandom_range(0, 7)); r.rs = 5'($urandom); r.rt = 5'($urandom);
    r.rd = 5'($urandom); r.funct = 6'($urandom); r.imm = 16'($urandom);
    r.target = 26'($urandom);
    return r;
  endfunction

  // Full session with model-derived expectations for writes, err and checksum.
  task automatic run_and_check(input string tag, input logic [7:0] base, input rec_t recs[$]);
    logic [39:0] exp_q[$];
    logic [31:0] w, cks;
    logic [7:0]  a;
    bit          e_err;
    got.delete();
    cks = 32'h0; e_err = 1'b0; a = base;
    foreach (recs[i]) begin
      if (model_encode(recs[i], w)) begin
        exp_q.push_back({a, w});
        cks = cks ^ w;
        a = a + 8'd1;
      end else begin
        e_err = 1'b1;
      end
    end
    start_session(base);
    foreach (recs[i]) begin
      if ($urandom_range(0, 3) == 0) tick();
      push_rec(recs[i]);
    end
    finish_session();
    wait_done({tag, "_done"});
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check({tag, "_addr"}, {24'h0, got[i][39:32]}, {24'h0, exp_q[i][39:32]});
      check({tag, "_data"}, got[i][31:0], exp_q[i][31:0]);
    end
    check({tag, "_err"}, {31'b0, err_o}, {31'b0, e_err});
    check({tag, "_checksum"}, checksum_o, CkEn ? cks : 32'h0);
    check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[6];
    rec_t        recs[$];
    logic [31:0] cks;

    vecs[0] = '{mk(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0), 32'h00221820};
    vecs[1] = '{mk(3'd1, 5'd0, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0), 32'h8C080004};
    vecs[2] = '{mk(3'd3, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0), 32'h1022FFFF};
    vecs[3] = '{mk(3'd4, 5'd0, 5'd5, 5'd0, 6'h0, 16'h0007, 26'h0), 32'h20050007};
    vecs[4] = '{mk(3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10), 32'h08000010};
    vecs[5] = '{mk(3'd2, 5'd29, 5'd31, 5'd0, 6'h0, 16'h0010, 26'h0), 32'hAFBF0010};

    rst_n = 1'b0; start_i = 1'b0; finish_i = 1'b0; in_valid_i = 1'b0; mem_ready_i = 1'b1;
    base_addr_i = 8'h0;
    drive_rec(mk(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0));
    #12;
    check("rst_in_ready", {31'b0, in_ready_o}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    check("rst_mem_addr", {24'h0, mem_addr_o}, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_busy_done_err", {29'b0, busy_o, done_o, err_o}, 32'd0);
    check("rst_checksum", checksum_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single-record sessions from the vector table, with first-write latency.
    for (int i = 0; i < 6; i++) begin
      got.delete();
      start_session(8'h10 + 8'(i));
      push_rec(vecs[i].r);
      check("latency_we", {31'b0, mem_we_o}, 32'd1);
      finish_session();
      wait_done("vec_done");
      check("vec_count", got.size(), 32'd1);
      if (got.size() > 0) begin
        check("vec_addr", {24'h0, got[0][39:32]}, 32'h10 + i);
        check("vec_data", got[0][31:0], vecs[i].word);
      end
      check("vec_busy", {31'b0, busy_o}, 32'd0);
      tick();
      check("vec_done_pulse", {31'b0, done_o}, 32'd0);
    end

    // Four records, last one accepted together with finish.
    got.delete();
    start_session(8'h10);
    for (int i = 1; i < 4; i++) push_rec(vecs[i].r);
    drive_rec(vecs[4].r);
    in_valid_i = 1'b1; finish_i = 1'b1;
    check("fin_with_rec_ready", {31'b0, in_ready_o}, 32'd1);
    tick();
    in_valid_i = 1'b0; finish_i = 1'b0;
    wait_done("four_done");
    check("four_count", got.size(), 32'd4);
    cks = 32'h0;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      check("four_addr", {24'h0, got[i][39:32]}, 32'h10 + i);
      check("four_data", got[i][31:0], vecs[i + 1].word);
      cks = cks ^ vecs[i + 1].word;
    end
    check("four_checksum", checksum_o, CkEn ? cks : 32'h0);

    // Back-pressure: FIFO fills at four, fifth waits until memory drains.
    got.delete();
    mem_ready_i = 1'b0;
    start_session(8'h20);
    for (int i = 0; i < 4; i++) push_rec(vecs[i].r);
    check("full_in_ready", {31'b0, in_ready_o}, 32'd0);
    check("stall_no_write", got.size(), 32'd0);
    mem_ready_i = 1'b1;
    push_rec(vecs[4].r);
    finish_session();
    wait_done("bp_done");
    check("bp_count", got.size(), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      check("bp_addr", {24'h0, got[i][39:32]}, 32'h20 + i);
      check("bp_data", got[i][31:0], vecs[i].word);
    end

    // Address wrap at the top of the space.
    got.delete();
    start_session(8'hFE);
    for (int i = 0; i < 3; i++) push_rec(vecs[i].r);
    finish_session();
    wait_done("wrap_done");
    check("wrap_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      check("wrap_a0", {24'h0, got[0][39:32]}, 32'hFE);
      check("wrap_a1", {24'h0, got[1][39:32]}, 32'hFF);
      check("wrap_a2", {24'h0, got[2][39:32]}, 32'h00);
    end

    // Illegal kind between two legal records.
    got.delete();
    start_session(8'h30);
    push_rec(vecs[0].r);
    push_rec(mk(3'd6, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1));
    push_rec(vecs[1].r);
    finish_session();
    wait_done("ill_done");
    check("ill_err", {31'b0, err_o}, 32'd1);
    check("ill_count", got.size(), 32'd2);
    if (got.size() == 2) begin
      check("ill_a0", {24'h0, got[0][39:32]}, 32'h30);
      check("ill_a1", {24'h0, got[1][39:32]}, 32'h31);
      check("ill_d1", got[1][31:0], vecs[1].word);
    end
    start_session(8'h00);
    check("err_cleared", {31'b0, err_o}, 32'd0);

    // Empty session: done two cycles after finish, no writes.
    got.delete();
    finish_i = 1'b1;
    tick();
    finish_i = 1'b0;
    check("empty_drain_busy", {30'b0, busy_o, done_o}, 32'd2);
    tick();
    check("empty_done", {30'b0, busy_o, done_o}, 32'd1);
    tick();
    check("empty_done_low", {31'b0, done_o}, 32'd0);
    check("empty_writes", got.size(), 32'd0);

    // start outside idle is ignored: base stays from the first start.
    got.delete();
    start_session(8'h50);
    start_session(8'h70);
    push_rec(vecs[0].r);
    finish_session();
    wait_done("restart_done");
    if (got.size() > 0) check("restart_addr", {24'h0, got[0][39:32]}, 32'h50);
    else check("restart_count", got.size(), 32'd1);

    // Reset in drain with two words queued.
    got.delete();
    mem_ready_i = 1'b0;
    start_session(8'h40);
    push_rec(vecs[0].r);
    push_rec(vecs[1].r);
    finish_session();
    check("drain_busy", {31'b0, busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    mem_ready_i = 1'b1;
    #1;
    check("rstd_mem_we", {31'b0, mem_we_o}, 32'd0);
    check("rstd_mem_addr", {24'h0, mem_addr_o}, 32'd0);
    check("rstd_mem_wdata", mem_wdata_o, 32'd0);
    check("rstd_flags", {28'b0, in_ready_o, busy_o, done_o, err_o}, 32'd0);
    check("rstd_checksum", checksum_o, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("rstd_no_writes", got.size(), 32'd0);
    check("rstd_idle", {31'b0, busy_o}, 32'd0);

    // Randomized sessions against the reference model.
    rnd_ready = 1'b1;
    for (int s = 0; s < 25; s++) begin
      recs.delete();
      for (int i = 0; i < $urandom_range(0, 10); i++) recs.push_back(rand_rec());
      run_and_check("rnd", 8'($urandom), recs);
    end
    rnd_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_instr_loader.md
# mips_instr_loader

Sequential encoder and loader for the single-cycle MIPS core. It accepts instruction descriptions as field-level records (class, registers, immediate, target) and encodes each one into a 32-bit MIPS word. Encoded words are buffered in a small FIFO and written sequentially into instruction memory from a programmable base address. It is the producer side of the opcode/control interface: it builds the instruction words that the main decoder later consumes. Benches and boot logic use it to fill instruction memory before the core is released.

## Interface
- ADDR_W, 8: instruction-memory word-address width.
- FIFO_DEPTH, 4: encoded-word buffer depth; power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; loads base_addr and begins a load session (honoured only in IDLE).
- base_addr  in  ADDR_W  first word address of the session.
- finish  in  1  one-cycle pulse; ends input acceptance (honoured only in LOAD).
- in_valid  in  1  instruction record valid.
- in_ready  out  1  record accepted when in_valid & in_ready.
- in_kind  in  3  0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6–7 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_funct  in  6  R-type funct.
- in_imm  in  16  I-type immediate.
- in_target  in  26  j target.
- mem_ready  in  1  memory can take a write this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded word.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky; an illegal in_kind was accepted in this session.
- checksum  out  32  see Configuration.

## Operation
- States: IDLE, LOAD, DRAIN.
  - IDLE→LOAD on start: address counter←base_addr, err←0, checksum←0, FIFO cleared.
  - LOAD→DRAIN on finish.
  - DRAIN→IDLE when the FIFO is empty and no write is pending; done pulses for one cycle on that transition.
- in_ready = (state==LOAD) & FIFO not full. No push on a full FIFO, even if a pop occurs in the same cycle.
- Encoding is performed at push:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}
  - lw: {6'b100011, rs, rt, imm}
  - sw: {6'b101011, rs, rt, imm}
  - beq: {6'b000100, rs, rt, imm}
  - addi: {6'b001000, rs, rt, imm}
  - j: {6'b000010, target}
- An illegal kind is accepted (handshake completes), not pushed, and sets err.
- Write: mem_we = FIFO not empty & mem_ready & (LOAD|DRAIN). mem_addr is the counter; mem_wdata is the FIFO head. Each write pops the FIFO and increments the counter.
- The counter wraps from 2^ADDR_W−1 to 0 silently.
- start outside IDLE and finish outside LOAD are ignored.
- Simultaneous finish and accepted record in LOAD: the record is kept, then the state moves to DRAIN.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err 0, checksum 0; state IDLE; FIFO empty.
- Reset mid-session aborts immediately; FIFO contents are discarded and no further writes occur.
- Latency: a record accepted at edge N produces mem_we in cycle N+1 if the FIFO was empty and mem_ready=1.
- Sustained throughput is one word per cycle while mem_ready=1.
- mem_ready low stalls writes. mem_we, mem_addr and mem_wdata are combinational from registered state and mem_ready.
- Empty session (start then finish, no records): done pulses 2 cycles after finish with no writes.

## Configuration
- MIPS_LOADER_CHECKSUM_EN defined: checksum is the XOR of every mem_wdata written this session. It is updated on each write, cleared on start, and held after done.
- Undefined: checksum is tied to 32'h0 and no accumulator logic is present.

## Test plan
- base_addr=0x10; push R-type rs=1 rt=2 rd=3 funct=0x20, then finish -> one write, addr 0x10, data 0x00221820; done pulses; busy falls.
- Push lw rs=0 rt=8 imm=4, beq rs=1 rt=2 imm=0xFFFF, addi rs=0 rt=5 imm=7, j target=0x10 -> addrs 0x10–0x13, data 0x8C080004, 0x1022FFFF, 0x20050007, 0x08000010. With MIPS_LOADER_CHECKSUM_EN, checksum equals the XOR of these four words.
- mem_ready=0 while pushing 5 records -> in_ready drops after 4 accepts. Raising mem_ready drains all 5 in order with no loss or duplication.
- base_addr=0xFE, 3 records -> writes at 0xFE, 0xFF, 0x00.
- in_kind=6 between two legal records -> err=1, exactly two writes at consecutive addresses; err is cleared by the next start.
- Assert rst_n=0 in DRAIN with 2 words queued -> all outputs return to reset values and no mem_we pulses after reset.
